// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator: ORDER integrators at the input rate, ORDER combs at the
// decimated rate, then round-half-up, arithmetic shift and saturate to OUT_W.
module cic_decimator_mc #(
    parameter int CHANNELS = 2,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int ORDER    = 4,
    parameter int MAX_R    = 128,
    parameter int R_W      = 8,
    localparam int ACC_W   = IN_W + ORDER * $clog2(MAX_R),
    localparam int SH_W    = $clog2(ACC_W)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*IN_W-1:0]  data_i,
    input  logic                      valid_i,
    input  logic [R_W-1:0]            rate_i,
    input  logic [SH_W-1:0]           shift_i,
    output logic [CHANNELS*OUT_W-1:0] data_o,
    output logic                      valid_o,
    output logic [CHANNELS-1:0]       sat_o
);

    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = -OUT_MAX - 1;

    logic signed [ACC_W-1:0] integ      [CHANNELS][ORDER];
    logic signed [ACC_W-1:0] integ_in   [CHANNELS][ORDER];
    logic signed [ACC_W-1:0] integ_next [CHANNELS][ORDER];

    logic [R_W-1:0] cnt;
    logic [R_W-1:0] rate_q;
    logic [R_W-1:0] rate_clamped;
    logic           dec_event;

    // Comb pipeline: index 0 is the decimated integrator sample, index ORDER the last comb output.
    logic signed [ACC_W-1:0] pipe_data [CHANNELS][ORDER+1];
    logic signed [ACC_W-1:0] pipe_prev [CHANNELS][ORDER];
    logic [SH_W-1:0]         pipe_sh   [ORDER+1];
    logic [ORDER:0]          pipe_vld;

    logic signed [ACC_W:0]   rnd_sum  [CHANNELS];
    logic signed [ACC_W:0]   shifted  [CHANNELS];
    logic [OUT_W-1:0]        sat_data [CHANNELS];
    logic [CHANNELS-1:0]     sat_flag;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        rate_clamped = rate_i;
        if (rate_i < R_W'(2)) begin
            rate_clamped = R_W'(2);
        end else if (rate_i > R_W'(MAX_R)) begin
            rate_clamped = R_W'(MAX_R);
        end
    end

    assign dec_event = valid_i && (cnt == rate_q - R_W'(1));

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            integ_in[c][0] = {{(ACC_W-IN_W){data_i[c*IN_W+IN_W-1]}}, data_i[c*IN_W +: IN_W]};
            for (int s = 1; s < ORDER; s++) begin
                integ_in[c][s] = integ[c][s-1];
            end
            for (int s = 0; s < ORDER; s++) begin
                integ_next[c][s] = integ[c][s] + integ_in[c][s];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the integrator chain relies on
    // every stage seeing the previous stage's old value. All state arrays are cleared on
    // reset so a mid-group reset restarts from a clean filter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            rate_q <= R_W'(MAX_R);
            for (int c = 0; c < CHANNELS; c++) begin
                for (int s = 0; s < ORDER; s++) begin
                    integ[c][s] <= '0;
                end
            end
        end else if (valid_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int s = 0; s < ORDER; s++) begin
                    integ[c][s] <= integ_next[c][s];
                end
            end
            if (cnt == '0) begin
                rate_q <= rate_clamped;
            end
            if (dec_event) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + R_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
            for (int j = 0; j <= ORDER; j++) begin
                pipe_sh[j] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                for (int j = 0; j <= ORDER; j++) begin
                    pipe_data[c][j] <= '0;
                end
                for (int j = 0; j < ORDER; j++) begin
                    pipe_prev[c][j] <= '0;
                end
            end
        end else begin
            pipe_vld <= {pipe_vld[ORDER-1:0], dec_event};
            if (dec_event) begin
                pipe_sh[0] <= shift_i;
                for (int c = 0; c < CHANNELS; c++) begin
                    pipe_data[c][0] <= integ_next[c][ORDER-1];
                end
            end
            // Each comb stage and its delay move only when its input sample is new.
            for (int j = 1; j <= ORDER; j++) begin
                if (pipe_vld[j-1]) begin
                    pipe_sh[j] <= pipe_sh[j-1];
                    for (int c = 0; c < CHANNELS; c++) begin
                        pipe_data[c][j]   <= pipe_data[c][j-1] - pipe_prev[c][j-1];
                        pipe_prev[c][j-1] <= pipe_data[c][j-1];
                    end
                end
            end
        end
    end

    always_comb begin
        sat_flag = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rnd_sum[c] = {pipe_data[c][ORDER][ACC_W-1], pipe_data[c][ORDER]};
            if (pipe_sh[ORDER] != '0) begin
                rnd_sum[c] = rnd_sum[c] + ((ACC_W+1)'(1) << (pipe_sh[ORDER] - SH_W'(1)));
            end
            shifted[c]  = rnd_sum[c] >>> pipe_sh[ORDER];
            sat_data[c] = shifted[c][OUT_W-1:0];
            if (shifted[c] > OUT_MAX) begin
                sat_data[c] = OUT_MAX[OUT_W-1:0];
                sat_flag[c] = 1'b1;
            end else if (shifted[c] < OUT_MIN) begin
                sat_data[c] = OUT_MIN[OUT_W-1:0];
                sat_flag[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            sat_o   <= '0;
        end else begin
            valid_o <= pipe_vld[ORDER];
            if (pipe_vld[ORDER]) begin
                sat_o <= sat_flag;
                for (int c = 0; c < CHANNELS; c++) begin
                    data_o[c*OUT_W +: OUT_W] <= sat_data[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Directed bench for cic_decimator_mc: DC gain, gapped input, saturation, rate change,
// rounding and rate clamping, with output timing checked against accepted inputs.
module tb_cic_decimator_mc;

    localparam int CHANNELS = 2;
    localparam int IN_W     = 32;
    localparam int OUT_W    = 16;
    localparam int R_W      = 8;
    localparam int SH_W     = 6;
    localparam int LAT      = 5;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [CHANNELS*IN_W-1:0]  data_i;
    logic                      valid_i;
    logic [R_W-1:0]            rate_i;
    logic [SH_W-1:0]           shift_i;
    logic [CHANNELS*OUT_W-1:0] data_o;
    logic                      valid_o;
    logic [CHANNELS-1:0]       sat_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int acc_cyc[$];
    int out_cyc[$];
    int out_d0[$];
    int out_d1[$];
    int out_sat[$];

    cic_decimator_mc dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .rate_i  (rate_i),
        .shift_i (shift_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sat_o   (sat_o)
    );

    always #8 clk_i = ~clk_i;

    task automatic set_inputs(input int ch0, input int ch1, input int rate, input int sh);
        data_i  = {IN_W'(ch1), IN_W'(ch0)};
        rate_i  = R_W'(rate);
        shift_i = SH_W'(sh);
    endtask

    // Advance one edge and sample the outputs 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (valid_o) begin
            out_cyc.push_back(cyc);
            out_d0.push_back(int'($signed(data_o[OUT_W-1:0])));
            out_d1.push_back(int'($signed(data_o[2*OUT_W-1:OUT_W])));
            out_sat.push_back(int'(sat_o));
        end
    endtask

    // Send n_valid samples, one every gap cycles, then idle long enough to drain the pipeline.
    task automatic run_stream(input int n_valid, input int gap);
        int k;
        int sent;
        acc_cyc.delete();
        out_cyc.delete();
        out_d0.delete();
        out_d1.delete();
        out_sat.delete();
        k    = 0;
        sent = 0;
        while (sent < n_valid) begin
            valid_i = ((k % gap) == 0);
            if (valid_i) begin
                acc_cyc.push_back(cyc + 1);
                sent++;
            end
            tick();
            k++;
        end
        valid_i = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_dc();
        set_inputs(1000, -1000, 8, 12);
        run_stream(80, 1);
        checks++;
        if (out_cyc.size() !== 10) begin
            errors++;
            $display("FAIL dc_count: got %0d outputs, expected 10", out_cyc.size());
        end
        for (int i = 0; i < out_cyc.size() && i < 10; i++) begin
            checks++;
            if (out_cyc[i] !== acc_cyc[8*i+7] + LAT) begin
                errors++;
                $display("FAIL dc_timing[%0d]: got cycle %0d, expected %0d", i, out_cyc[i], acc_cyc[8*i+7] + LAT);
            end
            if (i >= 4) begin
                checks++;
                if (out_d0[i] !== 1000 || out_d1[i] !== -1000 || out_sat[i] !== 0) begin
                    errors++;
                    $display("FAIL dc_value[%0d]: got %0d/%0d sat=%0d, expected 1000/-1000 sat=0",
                             i, out_d0[i], out_d1[i], out_sat[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        set_inputs(1000, -1000, 8, 12);
        run_stream(13, 1);
        #4;
        rst_i = 1'b1;
        #1;
        checks++;
        if (data_o !== '0 || valid_o !== 1'b0 || sat_o !== '0) begin
            errors++;
            $display("FAIL reset_async: got data=%h valid=%b sat=%b, expected all zero", data_o, valid_o, sat_o);
        end
        tick();
        tick();
        checks++;
        if (data_o !== '0 || valid_o !== 1'b0 || sat_o !== '0) begin
            errors++;
            $display("FAIL reset_hold: got data=%h valid=%b sat=%b, expected all zero", data_o, valid_o, sat_o);
        end
        rst_i = 1'b0;
        test_dc();
    endtask

    task automatic test_gapped();
        set_inputs(1000, -1000, 8, 12);
        run_stream(80, 3);
        checks++;
        if (out_cyc.size() !== 10) begin
            errors++;
            $display("FAIL gap_count: got %0d outputs, expected 10", out_cyc.size());
        end
        for (int i = 0; i < out_cyc.size() && i < 10; i++) begin
            checks++;
            if (out_cyc[i] !== acc_cyc[8*i+7] + LAT) begin
                errors++;
                $display("FAIL gap_timing[%0d]: got cycle %0d, expected %0d", i, out_cyc[i], acc_cyc[8*i+7] + LAT);
            end
            if (i >= 1) begin
                checks++;
                if (out_cyc[i] - out_cyc[i-1] !== 24) begin
                    errors++;
                    $display("FAIL gap_period[%0d]: got %0d, expected 24", i, out_cyc[i] - out_cyc[i-1]);
                end
            end
            checks++;
            if (out_d0[i] !== 1000 || out_d1[i] !== -1000 || out_sat[i] !== 0) begin
                errors++;
                $display("FAIL gap_value[%0d]: got %0d/%0d sat=%0d, expected 1000/-1000 sat=0",
                         i, out_d0[i], out_d1[i], out_sat[i]);
            end
        end
    endtask

    task automatic test_saturation();
        set_inputs(1 << 20, -(1 << 20), 8, 0);
        run_stream(80, 1);
        checks++;
        if (out_cyc.size() !== 10) begin
            errors++;
            $display("FAIL sat_count: got %0d outputs, expected 10", out_cyc.size());
        end
        for (int i = 4; i < out_cyc.size() && i < 10; i++) begin
            checks++;
            if (out_d0[i] !== 32767 || out_d1[i] !== -32768 || out_sat[i] !== 3) begin
                errors++;
                $display("FAIL sat_value[%0d]: got %0d/%0d sat=%0d, expected 32767/-32768 sat=3",
                         i, out_d0[i], out_d1[i], out_sat[i]);
            end
        end
    endtask

    task automatic test_rate_change();
        set_inputs(1000, -1000, 8, 12);
        run_stream(80, 1);
        for (int i = 4; i < out_cyc.size() && i < 10; i++) begin
            checks++;
            if (out_d0[i] !== 1000 || out_d1[i] !== -1000) begin
                errors++;
                $display("FAIL rc_resettle[%0d]: got %0d/%0d, expected 1000/-1000", i, out_d0[i], out_d1[i]);
            end
        end
        run_stream(3, 1);
        checks++;
        if (out_cyc.size() !== 0) begin
            errors++;
            $display("FAIL rc_early: got %0d outputs after 3 samples, expected 0", out_cyc.size());
        end
        // Five more samples close the 8-sample group, then groups of 16.
        set_inputs(1000, -1000, 16, 16);
        run_stream(165, 1);
        checks++;
        if (out_cyc.size() !== 11) begin
            errors++;
            $display("FAIL rc_count: got %0d outputs, expected 11", out_cyc.size());
        end
        for (int j = 0; j < out_cyc.size() && j < 11; j++) begin
            checks++;
            if (out_cyc[j] !== acc_cyc[4+16*j] + LAT) begin
                errors++;
                $display("FAIL rc_timing[%0d]: got cycle %0d, expected %0d", j, out_cyc[j], acc_cyc[4+16*j] + LAT);
            end
            if (j >= 5) begin
                checks++;
                if (out_d0[j] !== 1000 || out_d1[j] !== -1000 || out_sat[j] !== 0) begin
                    errors++;
                    $display("FAIL rc_value[%0d]: got %0d/%0d sat=%0d, expected 1000/-1000 sat=0",
                             j, out_d0[j], out_d1[j], out_sat[j]);
                end
            end
        end
    endtask

    task automatic test_rounding_clamp();
        // Gain 2^4 = 16: 48/32 = 1.5 -> 2, and -48/32 = -1.5 -> -1 (round half up).
        set_inputs(3, -3, 2, 5);
        run_stream(40, 1);
        checks++;
        if (out_cyc.size() !== 20) begin
            errors++;
            $display("FAIL rnd_count: got %0d outputs, expected 20", out_cyc.size());
        end
        for (int i = 0; i < out_cyc.size() && i < 20; i++) begin
            checks++;
            if (out_cyc[i] !== acc_cyc[2*i+1] + LAT) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: got cycle %0d, expected %0d", i, out_cyc[i], acc_cyc[2*i+1] + LAT);
            end
            if (i >= 5) begin
                checks++;
                if (out_d0[i] !== 2 || out_d1[i] !== -1 || out_sat[i] !== 0) begin
                    errors++;
                    $display("FAIL rnd_value[%0d]: got %0d/%0d sat=%0d, expected 2/-1 sat=0",
                             i, out_d0[i], out_d1[i], out_sat[i]);
                end
            end
        end

        set_inputs(3, -3, 0, 5);
        run_stream(20, 1);
        checks++;
        if (out_cyc.size() !== 10) begin
            errors++;
            $display("FAIL clamp_low_count: got %0d outputs, expected 10", out_cyc.size());
        end
        for (int i = 0; i < out_cyc.size() && i < 10; i++) begin
            checks++;
            if (out_cyc[i] !== acc_cyc[2*i+1] + LAT || out_d0[i] !== 2 || out_d1[i] !== -1) begin
                errors++;
                $display("FAIL clamp_low[%0d]: got cycle %0d value %0d/%0d, expected cycle %0d value 2/-1",
                         i, out_cyc[i], out_d0[i], out_d1[i], acc_cyc[2*i+1] + LAT);
            end
        end

        set_inputs(3, -3, 200, 5);
        run_stream(256, 1);
        checks++;
        if (out_cyc.size() !== 2) begin
            errors++;
            $display("FAIL clamp_high_count: got %0d outputs, expected 2", out_cyc.size());
        end
        for (int i = 0; i < out_cyc.size() && i < 2; i++) begin
            checks++;
            if (out_cyc[i] !== acc_cyc[128*i+127] + LAT) begin
                errors++;
                $display("FAIL clamp_high_timing[%0d]: got cycle %0d, expected %0d",
                         i, out_cyc[i], acc_cyc[128*i+127] + LAT);
            end
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        set_inputs(0, 0, 8, 12);
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        test_dc();
        test_reset();
        test_gapped();
        test_saturation();
        test_rate_change();
        test_rounding_clamp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
